// File: rtl/display_pkg.sv
// Shared types and default geometry for the display sequencer.
// The top module and the raster counter both import this package.
package display_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DRAW  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  localparam int CW_DEF       = 12;
  localparam int H_PIX_DEF    = 160;
  localparam int V_PIX_DEF    = 120;
  localparam int HOLD_CYC_DEF = 25000000;

endpackage

// File: rtl/raster_counter.sv
// Raster x/y sweep used to clear the frame buffer.
// It wraps x at the end of each line and flags the final pixel of the frame.
module raster_counter
  import display_pkg::*;
#(
  parameter int H_PIX = H_PIX_DEF,
  parameter int V_PIX = V_PIX_DEF,
  parameter int XW    = 8,
  parameter int YW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  localparam int XCW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int YCW = (V_PIX > 1) ? $clog2(V_PIX) : 1;
  localparam logic [XCW-1:0] X_LAST = XCW'(H_PIX - 1);
  localparam logic [YCW-1:0] Y_LAST = YCW'(V_PIX - 1);

  logic [XCW-1:0] x_q, x_d;
  logic [YCW-1:0] y_q, y_d;
  logic           x_last;

  assign x_last = (x_q == X_LAST);
  assign last_o = x_last && (y_q == Y_LAST);
  assign x_o    = XW'(x_q);
  assign y_o    = YW'(y_q);

  always_comb begin
    // NOTE: defaults first so every path assigns x_d/y_d and no latch is inferred.
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      if (x_last) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/display_sequencer.sv
// Frame sequencer: clears the buffer, arbitrates draw engines one at a time,
// then holds the finished frame before idling or restarting.
module display_sequencer
  import display_pkg::*;
#(
  parameter int H_PIX    = H_PIX_DEF,
  parameter int V_PIX    = V_PIX_DEF,
  parameter int XW       = 8,
  parameter int YW       = 8,
  parameter int NCH      = 2,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              auto_mode,
  input  logic [CW-1:0]     bg_color,
  input  logic              wr_ready,
  output logic [XW-1:0]     CounterX,
  output logic [YW-1:0]     CounterY,
  output logic [CW-1:0]     color,
  output logic              wr_en,
  output logic [NCH-1:0]    lock,
  input  logic [NCH-1:0]    eng_valid,
  input  logic [NCH*XW-1:0] eng_x,
  input  logic [NCH*YW-1:0] eng_y,
  input  logic [NCH*CW-1:0] eng_color,
  input  logic [NCH-1:0]    eng_done,
  output logic [NCH-1:0]    eng_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW-1:0] CH_LAST   = CHW'(NCH - 1);
  localparam logic [XW-1:0]  X_LIM     = XW'(H_PIX);
  localparam logic [YW-1:0]  Y_LIM     = YW'(V_PIX);
  localparam logic [31:0]    HOLD_LAST = 32'(HOLD_CYC - 1);

  state_e         state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [31:0]    hold_q, hold_d;

  // One-deep output stage between the granted engine and the frame buffer.
  logic           ov_q, ov_d;
  logic [XW-1:0]  ox_q, ox_d;
  logic [YW-1:0]  oy_q, oy_d;
  logic [CW-1:0]  oc_q, oc_d;

  logic [XW-1:0]  rx;
  logic [YW-1:0]  ry;
  logic           r_last;

  logic           sel_valid, sel_done, in_range, take, load;
  logic [XW-1:0]  sel_x;
  logic [YW-1:0]  sel_y;
  logic [CW-1:0]  sel_c;

  raster_counter #(
    .H_PIX (H_PIX),
    .V_PIX (V_PIX),
    .XW    (XW),
    .YW    (YW)
  ) u_raster (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != S_CLEAR),
    .adv_i  ((state_q == S_CLEAR) && wr_ready),
    .x_o    (rx),
    .y_o    (ry),
    .last_o (r_last)
  );

  always_comb begin
    sel_valid = eng_valid[ch_q];
    sel_done  = eng_done[ch_q];
    sel_x     = eng_x[int'(ch_q)*XW +: XW];
    sel_y     = eng_y[int'(ch_q)*YW +: YW];
    sel_c     = eng_color[int'(ch_q)*CW +: CW];
  end

  assign in_range = (sel_x < X_LIM) && (sel_y < Y_LIM);
  assign take     = (state_q == S_DRAW) && (!ov_q || wr_ready);
  // Off-screen coordinates are consumed but never reach the output stage.
  assign load     = take && sel_valid && in_range;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    hold_d     = hold_q;
    ov_d       = ov_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    oc_d       = oc_q;
    CounterX   = '0;
    CounterY   = '0;
    color      = '0;
    wr_en      = 1'b0;
    lock       = '0;
    eng_ready  = '0;
    frame_done = 1'b0;
    busy       = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          ch_d    = '0;
        end
      end
      S_CLEAR: begin
        wr_en    = 1'b1;
        CounterX = rx;
        CounterY = ry;
        color    = bg_color;
        if (wr_ready && r_last) begin
          state_d = S_DRAW;
          ch_d    = '0;
        end
      end
      S_DRAW: begin
        lock[ch_q]      = 1'b1;
        eng_ready[ch_q] = take;
        wr_en           = ov_q;
        CounterX        = ox_q;
        CounterY        = oy_q;
        color           = oc_q;
        if (ov_q && wr_ready) ov_d = 1'b0;
        if (load) begin
          ov_d = 1'b1;
          ox_d = sel_x;
          oy_d = sel_y;
          oc_d = sel_c;
        end
        // Hand over only once nothing from this engine is still in flight.
        if (sel_done && !ov_q && !load) begin
          if (ch_q == CH_LAST) begin
            state_d = S_HOLD;
            hold_d  = '0;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        hold_d = hold_q + 32'd1;
        if (hold_q == HOLD_LAST) begin
          frame_done = 1'b1;
          state_d    = auto_mode ? S_CLEAR : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      ch_d    = '0;
      ov_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      hold_q  <= '0;
      ov_q    <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      oc_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      hold_q  <= hold_d;
      ov_q    <= ov_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oc_q    <= oc_d;
    end
  end

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer on a 4x3 frame with two engines.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_display_sequencer;
  import display_pkg::*;

  localparam int H_PIX = 4, V_PIX = 3, XW = 8, YW = 8, NCH = 2, HOLD_CYC = 5, CW = 12;

  logic              clk = 1'b0;
  logic              rst, start, abort, auto_mode, wr_ready;
  logic [CW-1:0]     bg_color;
  logic [XW-1:0]     CounterX;
  logic [YW-1:0]     CounterY;
  logic [CW-1:0]     color;
  logic              wr_en, busy, frame_done;
  logic [NCH-1:0]    lock, eng_valid, eng_done, eng_ready;
  logic [NCH*XW-1:0] eng_x;
  logic [NCH*YW-1:0] eng_y;
  logic [NCH*CW-1:0] eng_color;

  int tests = 0;
  int fails = 0;

  display_sequencer #(
    .H_PIX(H_PIX), .V_PIX(V_PIX), .XW(XW), .YW(YW),
    .NCH(NCH), .HOLD_CYC(HOLD_CYC), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .auto_mode(auto_mode),
    .bg_color(bg_color), .wr_ready(wr_ready), .CounterX(CounterX), .CounterY(CounterY),
    .color(color), .wr_en(wr_en), .lock(lock), .eng_valid(eng_valid), .eng_x(eng_x),
    .eng_y(eng_y), .eng_color(eng_color), .eng_done(eng_done), .eng_ready(eng_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pixel(input string tag, input int p, input logic [CW-1:0] c);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd1);
    check({tag, "_x"}, 32'(CounterX), 32'(p % H_PIX));
    check({tag, "_y"}, 32'(CounterY), 32'(p / H_PIX));
    check({tag, "_color"}, 32'(color), 32'(c));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, 32'(CounterX), 32'd0);
    check({tag, "_y"}, 32'(CounterY), 32'd0);
    check({tag, "_color"}, 32'(color), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_lock"}, 32'(lock), 32'd0);
    check({tag, "_eng_ready"}, 32'(eng_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, cyc;
    logic rdy;
    rst = 1'b1; start = 1'b0; abort = 1'b0; auto_mode = 1'b0; wr_ready = 1'b1;
    bg_color = 12'h00F; eng_valid = '0; eng_done = '0;
    eng_x = '0; eng_y = '0; eng_color = '0;

    // Reset state
    #3 check_all_zero("reset");
    tick(); rst = 1'b0;

    // Frame A: clear sweep with continuous acceptance
    start = 1'b1; tick(); start = 1'b0;
    check("clear_busy", 32'(busy), 32'd1);
    check("clear_lock", 32'(lock), 32'd0);
    for (int i = 0; i < H_PIX * V_PIX; i++) begin
      check_pixel("sweep", i, 12'h00F);
      tick();
    end
    check("draw_lock0", 32'(lock), 32'h1);
    check("draw_idle_wr", 32'(wr_en), 32'd0);

    // Engine 0: one on-screen write, then one off-screen write
    eng_valid = 2'b01; eng_x = {8'd0, 8'd1}; eng_y = {8'd0, 8'd1}; eng_color = {12'h000, 12'hF00};
    #1 check("eng_ready_empty", 32'(eng_ready), 32'h1);
    tick();
    check("draw_wr_en", 32'(wr_en), 32'd1);
    check("draw_x", 32'(CounterX), 32'd1);
    check("draw_y", 32'(CounterY), 32'd1);
    check("draw_color", 32'(color), 32'hF00);
    eng_x = {8'd0, 8'd9}; eng_y = {8'd0, 8'd0}; eng_color = {12'h000, 12'h0F0};
    #1 check("eng_ready_accept", 32'(eng_ready), 32'h1);
    tick();
    check("offscreen_dropped", 32'(wr_en), 32'd0);
    eng_valid = 2'b00; eng_done = 2'b01;
    tick();
    check("draw_lock1", 32'(lock), 32'h2);
    check("eng_ready_ch1", 32'(eng_ready), 32'h2);
    eng_done = 2'b01;
    tick();
    check("other_done_ignored", 32'(lock), 32'h2);
    eng_done = 2'b10;
    tick();
    eng_done = 2'b00;
    check("hold_lock", 32'(lock), 32'd0);
    check("hold_busy", 32'(busy), 32'd1);
    for (int k = 0; k < HOLD_CYC; k++) begin
      check($sformatf("hold_fd%0d", k), 32'(frame_done), (k == HOLD_CYC - 1) ? 32'd1 : 32'd0);
      tick();
    end
    check("after_hold_idle", 32'(busy), 32'd0);
    check("after_hold_fd", 32'(frame_done), 32'd0);

    // Frame B: clear with wr_ready toggling 1,0
    start = 1'b1; tick(); start = 1'b0;
    p = 0; cyc = 0; rdy = 1'b1;
    while (p < H_PIX * V_PIX && cyc < 40) begin
      check_pixel("bp", p, 12'h00F);
      wr_ready = rdy;
      if (rdy) p++;
      rdy = ~rdy;
      cyc++;
      tick();
    end
    check("bp_accepted", 32'(p), 32'(H_PIX * V_PIX));
    check("bp_lock0", 32'(lock), 32'h1);
    wr_ready = 1'b1;

    // Auto mode: straight back into CLEAR after frame_done
    auto_mode = 1'b1;
    eng_done = 2'b01; tick();
    eng_done = 2'b10; tick();
    eng_done = 2'b00;
    for (int k = 0; k < HOLD_CYC; k++) begin
      check($sformatf("auto_fd%0d", k), 32'(frame_done), (k == HOLD_CYC - 1) ? 32'd1 : 32'd0);
      tick();
    end
    check_pixel("auto_restart", 0, 12'h00F);
    check("auto_busy", 32'(busy), 32'd1);
    auto_mode = 1'b0;

    // Frame C: abort at pixel (2,1)
    for (int i = 0; i < 6; i++) tick();
    check_pixel("pre_abort", 6, 12'h00F);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_lock", 32'(lock), 32'd0);

    // abort wins over start
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    check("abort_start_busy", 32'(busy), 32'd0);
    check("abort_start_wr", 32'(wr_en), 32'd0);

    // Frame D: reset while a DRAW write is pending
    start = 1'b1; tick(); start = 1'b0;
    check_pixel("d_first", 0, 12'h00F);
    for (int i = 0; i < H_PIX * V_PIX; i++) tick();
    check("d_lock0", 32'(lock), 32'h1);
    eng_valid = 2'b01; eng_x = {8'd0, 8'd2}; eng_y = {8'd0, 8'd2}; eng_color = {12'h000, 12'hABC};
    wr_ready = 1'b0;
    tick();
    check("d_pending_wr", 32'(wr_en), 32'd1);
    check("d_pending_color", 32'(color), 32'hABC);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_draw_rst");
    tick(); rst = 1'b0; eng_valid = 2'b00; wr_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check_pixel("post_rst", 0, 12'h00F);
    abort = 1'b1; tick(); abort = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
